mem_access_stage: RTL and testbench

//  MEM stage of the ARM pipeline. Consumes the EX/MEM pipeline register outputs and performs

---
 rtl/mem_access_stage.sv | 207 ++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - ARM pipeline MEM stage: req/ack data-memory access, load alignment, one result per instruction
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        reg_write_enable_in,
  input  logic        mem_write_enable_in,
  input  logic        mem_read_enable_in,
  input  logic        mem_byte_in,
  input  logic        mem_signed_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic [3:0]  rd_in,
  output logic        stall_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wb_valid,
  output logic        reg_write_enable_out,
  output logic [3:0]  rd_out,
  output logic [31:0] wb_data_out,
  output logic        align_fault,
  output logic        bus_fault
);
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic          wb_valid_q, wb_valid_d, reg_we_out_q, reg_we_out_d;
  logic [3:0]    rd_out_q, rd_out_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic          align_fault_q, align_fault_d, bus_fault_q, bus_fault_d;
  // Instruction held for the duration of an access
  logic          cap_load_q, cap_load_d, cap_byte_q, cap_byte_d;
  logic          cap_signed_q, cap_signed_d, cap_rwe_q, cap_rwe_d;
  logic [1:0]    cap_lane_q, cap_lane_d;
  logic [31:0]   cap_alu_q, cap_alu_d;
  logic [3:0]    cap_rd_q, cap_rd_d;

  logic [7:0]    load_byte;
  logic [31:0]   load_data;

  always_comb begin
    load_byte = 8'h00;
    case (cap_lane_q)
      2'd0: load_byte = mem_rdata[7:0];
      2'd1: load_byte = mem_rdata[15:8];
      2'd2: load_byte = mem_rdata[23:16];
      2'd3: load_byte = mem_rdata[31:24];
      default: load_byte = 8'h00;
    endcase
    if (!cap_byte_q)
      load_data = mem_rdata;
    else if (cap_signed_q)
      load_data = {{24{load_byte[7]}}, load_byte};
    else
      load_data = {24'h0, load_byte};
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_be_d      = mem_be_q;
    wb_valid_d    = 1'b0;
    reg_we_out_d  = 1'b0;
    rd_out_d      = rd_out_q;
    wb_data_d     = wb_data_q;
    align_fault_d = 1'b0;
    bus_fault_d   = 1'b0;
    cap_load_d    = cap_load_q;
    cap_byte_d    = cap_byte_q;
    cap_signed_d  = cap_signed_q;
    cap_rwe_d     = cap_rwe_q;
    cap_lane_d    = cap_lane_q;
    cap_alu_d     = cap_alu_q;
    cap_rd_d      = cap_rd_q;

    case (state_q)
      IDLE: begin
        if (valid_in) begin
          if (!mem_read_enable_in && !mem_write_enable_in) begin
            wb_valid_d   = 1'b1;
            reg_we_out_d = reg_write_enable_in;
            rd_out_d     = rd_in;
            wb_data_d    = alu_result_in;
          end else if (!mem_byte_in && alu_result_in[1:0] != 2'b00) begin
            wb_valid_d    = 1'b1;
            align_fault_d = 1'b1;
            rd_out_d      = rd_in;
            wb_data_d     = alu_result_in;
          end else begin
            state_d      = ACCESS;
            cnt_d        = '0;
            mem_req_d    = 1'b1;
            mem_we_d     = mem_write_enable_in;
            mem_addr_d   = {alu_result_in[31:2], 2'b00};
            mem_be_d     = mem_byte_in ? (4'b0001 << alu_result_in[1:0]) : 4'hF;
            mem_wdata_d  = mem_byte_in ? {4{store_data_in[7:0]}} : store_data_in;
            cap_load_d   = !mem_write_enable_in;
            cap_byte_d   = mem_byte_in;
            cap_signed_d = mem_signed_in;
            cap_rwe_d    = reg_write_enable_in;
            cap_lane_d   = alu_result_in[1:0];
            cap_alu_d    = alu_result_in;
            cap_rd_d     = rd_in;
          end
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          state_d      = IDLE;
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          wb_valid_d   = 1'b1;
          reg_we_out_d = cap_rwe_q;
          rd_out_d     = cap_rd_q;
          wb_data_d    = cap_load_q ? load_data : cap_alu_q;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          wb_valid_d  = 1'b1;
          bus_fault_d = 1'b1;
          rd_out_d    = cap_rd_q;
          wb_data_d   = cap_alu_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_be_q      <= '0;
      wb_valid_q    <= 1'b0;
      reg_we_out_q  <= 1'b0;
      rd_out_q      <= '0;
      wb_data_q     <= '0;
      align_fault_q <= 1'b0;
      bus_fault_q   <= 1'b0;
      cap_load_q    <= 1'b0;
      cap_byte_q    <= 1'b0;
      cap_signed_q  <= 1'b0;
      cap_rwe_q     <= 1'b0;
      cap_lane_q    <= '0;
      cap_alu_q     <= '0;
      cap_rd_q      <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_be_q      <= mem_be_d;
      wb_valid_q    <= wb_valid_d;
      reg_we_out_q  <= reg_we_out_d;
      rd_out_q      <= rd_out_d;
      wb_data_q     <= wb_data_d;
      align_fault_q <= align_fault_d;
      bus_fault_q   <= bus_fault_d;
      cap_load_q    <= cap_load_d;
      cap_byte_q    <= cap_byte_d;
      cap_signed_q  <= cap_signed_d;
      cap_rwe_q     <= cap_rwe_d;
      cap_lane_q    <= cap_lane_d;
      cap_alu_q     <= cap_alu_d;
      cap_rd_q      <= cap_rd_d;
    end
  end

  assign stall_out            = (state_q == ACCESS);
  assign mem_req              = mem_req_q;
  assign mem_we               = mem_we_q;
  assign mem_addr             = mem_addr_q;
  assign mem_wdata            = mem_wdata_q;
  assign mem_be               = mem_be_q;
  assign wb_valid             = wb_valid_q;
  assign reg_write_enable_out = reg_we_out_q;
  assign rd_out               = rd_out_q;
  assign wb_data_out          = wb_data_q;
  assign align_fault          = align_fault_q;
  assign bus_fault            = bus_fault_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in, reg_write_enable_in, mem_write_enable_in, mem_read_enable_in;
  logic        mem_byte_in, mem_signed_in;
  logic [31:0] alu_result_in, store_data_in;
  logic [3:0]  rd_in;
  logic        stall_out, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        wb_valid, reg_write_enable_out;
  logic [3:0]  rd_out;
  logic [31:0] wb_data_out;
  logic        align_fault, bus_fault;

  int total = 0;
  int bad = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in),
    .reg_write_enable_in(reg_write_enable_in), .mem_write_enable_in(mem_write_enable_in),
    .mem_read_enable_in(mem_read_enable_in), .mem_byte_in(mem_byte_in),
    .mem_signed_in(mem_signed_in), .alu_result_in(alu_result_in),
    .store_data_in(store_data_in), .rd_in(rd_in), .stall_out(stall_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .wb_valid(wb_valid),
    .reg_write_enable_out(reg_write_enable_out), .rd_out(rd_out),
    .wb_data_out(wb_data_out), .align_fault(align_fault), .bus_fault(bus_fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single capture edge, then withdraw it
  task automatic issue(input logic rwe, input logic we, input logic re, input logic byt,
                       input logic sgn, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [3:0] rd);
    valid_in = 1'b1; reg_write_enable_in = rwe; mem_write_enable_in = we;
    mem_read_enable_in = re; mem_byte_in = byt; mem_signed_in = sgn;
    alu_result_in = alu; store_data_in = sd; rd_in = rd;
    step();
    valid_in = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; valid_in = 1'b0; reg_write_enable_in = 1'b0; mem_write_enable_in = 1'b0;
    mem_read_enable_in = 1'b0; mem_byte_in = 1'b0; mem_signed_in = 1'b0;
    alu_result_in = '0; store_data_in = '0; rd_in = '0; mem_rdata = '0; mem_ack = 1'b1;
    step(); step();
    total++; if ({mem_req, stall_out, wb_valid, align_fault, bus_fault, mem_we} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=000000", {mem_req, stall_out, wb_valid, align_fault, bus_fault, mem_we}); end
    total++; if ({mem_addr, mem_wdata, wb_data_out} !== 96'h0) begin
      bad++; $display("FAIL reset_buses got=%h exp=0", {mem_addr, mem_wdata, wb_data_out}); end
    reset = 1'b0;
    step();
    total++; if (wb_valid !== 1'b0 || stall_out !== 1'b0) begin
      bad++; $display("FAIL reset_ack_ignored got=%b%b exp=00", wb_valid, stall_out); end
    mem_ack = 1'b0;
  endtask

  task automatic test_alu_passthrough();
    issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h0, 4'd3);
    total++; if (wb_valid !== 1'b1 || reg_write_enable_out !== 1'b1 || stall_out !== 1'b0) begin
      bad++; $display("FAIL add_ctrl got=%b%b%b exp=110", wb_valid, reg_write_enable_out, stall_out); end
    total++; if (rd_out !== 4'd3 || wb_data_out !== 32'h1234) begin
      bad++; $display("FAIL add_data got=%0d/%h exp=3/00001234", rd_out, wb_data_out); end
    step();
    total++; if (wb_valid !== 1'b0 || reg_write_enable_out !== 1'b0 || wb_data_out !== 32'h1234) begin
      bad++; $display("FAIL add_hold got=%b%b/%h exp=00/00001234", wb_valid, reg_write_enable_out, wb_data_out); end
  endtask

  task automatic test_load_byte(input logic sgn, input logic [31:0] exp_data);
    int stalls = 0;
    issue(1'b1, 1'b0, 1'b1, 1'b1, sgn, 32'h1003, 32'h0, 4'd5);
    total++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_be !== 4'b1000 || mem_addr !== 32'h1000) begin
      bad++; $display("FAIL ldrb_req got=%b%b/%b/%h exp=10/1000/00001000", mem_req, mem_we, mem_be, mem_addr); end
    for (int i = 0; i < 3; i++) begin
      if (stall_out === 1'b1) stalls++;
      if (i == 2) begin mem_ack = 1'b1; mem_rdata = 32'h80FF_FF00; end
      step();
    end
    mem_ack = 1'b0; mem_rdata = '0;
    total++; if (stalls != 3) begin
      bad++; $display("FAIL ldrb_stall got=%0d exp=3", stalls); end
    total++; if (wb_valid !== 1'b1 || stall_out !== 1'b0 || mem_req !== 1'b0 || reg_write_enable_out !== 1'b1) begin
      bad++; $display("FAIL ldrb_done got=%b%b%b%b exp=1001", wb_valid, stall_out, mem_req, reg_write_enable_out); end
    total++; if (wb_data_out !== exp_data || rd_out !== 4'd5) begin
      bad++; $display("FAIL ldrb_data got=%h/%0d exp=%h/5", wb_data_out, rd_out, exp_data); end
    step();
  endtask

  task automatic test_store_byte();
    issue(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h2001, 32'h1234_56AB, 4'd7);
    total++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b0010) begin
      bad++; $display("FAIL strb_req got=%b%b/%b exp=11/0010", mem_req, mem_we, mem_be); end
    total++; if (mem_wdata !== 32'hABAB_ABAB || mem_addr !== 32'h2000) begin
      bad++; $display("FAIL strb_bus got=%h/%h exp=abababab/00002000", mem_wdata, mem_addr); end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    total++; if (wb_valid !== 1'b1 || reg_write_enable_out !== 1'b0 || wb_data_out !== 32'h2001) begin
      bad++; $display("FAIL strb_done got=%b%b/%h exp=10/00002001", wb_valid, reg_write_enable_out, wb_data_out); end
    step();
  endtask

  task automatic test_align_fault();
    issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h2002, 32'h0, 4'd2);
    total++; if (mem_req !== 1'b0 || stall_out !== 1'b0 || align_fault !== 1'b1) begin
      bad++; $display("FAIL align_pulse got=%b%b%b exp=001", mem_req, stall_out, align_fault); end
    total++; if (wb_valid !== 1'b1 || reg_write_enable_out !== 1'b0) begin
      bad++; $display("FAIL align_wb got=%b%b exp=10", wb_valid, reg_write_enable_out); end
    step();
    total++; if (align_fault !== 1'b0 || wb_valid !== 1'b0) begin
      bad++; $display("FAIL align_clear got=%b%b exp=00", align_fault, wb_valid); end
  endtask

  task automatic test_timeout(input logic ack_last);
    int req_cycles = 0;
    issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h3000, 32'h0, 4'd9);
    while (mem_req === 1'b1 && req_cycles < 20) begin
      req_cycles++;
      if (ack_last && req_cycles == 8) begin mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D; end
      step();
    end
    mem_ack = 1'b0;
    total++; if (req_cycles != 8) begin
      bad++; $display("FAIL timeout_req_cycles ack=%b got=%0d exp=8", ack_last, req_cycles); end
    total++; if (bus_fault !== !ack_last || wb_valid !== 1'b1 || stall_out !== 1'b0) begin
      bad++; $display("FAIL timeout_end ack=%b got=%b%b%b exp=%b10", ack_last, bus_fault, wb_valid, stall_out, !ack_last); end
    total++; if (reg_write_enable_out !== ack_last) begin
      bad++; $display("FAIL timeout_regwe got=%b exp=%b", reg_write_enable_out, ack_last); end
    if (ack_last) begin
      total++; if (wb_data_out !== 32'hCAFE_F00D) begin
        bad++; $display("FAIL timeout_ack_data got=%h exp=cafef00d", wb_data_out); end
    end
    step();
    total++; if (bus_fault !== 1'b0 || wb_valid !== 1'b0) begin
      bad++; $display("FAIL timeout_clear got=%b%b exp=00", bus_fault, wb_valid); end
  endtask

  task automatic test_reset_mid_access();
    issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h4000, 32'h0, 4'd4);
    step();
    total++; if (stall_out !== 1'b1 || mem_req !== 1'b1) begin
      bad++; $display("FAIL midrst_pre got=%b%b exp=11", stall_out, mem_req); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (mem_req !== 1'b0 || stall_out !== 1'b0 || wb_valid !== 1'b0) begin
      bad++; $display("FAIL midrst_post got=%b%b%b exp=000", mem_req, stall_out, wb_valid); end
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    step();
    mem_ack = 1'b0;
    total++; if (wb_valid !== 1'b0 || stall_out !== 1'b0 || wb_data_out !== 32'h0) begin
      bad++; $display("FAIL midrst_late_ack got=%b%b/%h exp=00/0", wb_valid, stall_out, wb_data_out); end
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0040, 32'h0, 4'd1);
    valid_in = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    step();
    mem_ack = 1'b0;
    total++; if (wb_valid !== 1'b1 || wb_data_out !== 32'h5555_AAAA || stall_out !== 1'b0) begin
      bad++; $display("FAIL b2b_load got=%b/%h/%b exp=1/5555aaaa/0", wb_valid, wb_data_out, stall_out); end
    issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0BEE, 32'h0, 4'd6);
    total++; if (wb_valid !== 1'b1 || wb_data_out !== 32'h0BEE || rd_out !== 4'd6) begin
      bad++; $display("FAIL b2b_next got=%b/%h/%0d exp=1/00000bee/6", wb_valid, wb_data_out, rd_out); end
    step();
  endtask

  initial begin
    test_reset();
    test_alu_passthrough();
    test_load_byte(1'b1, 32'hFFFF_FF80);
    test_load_byte(1'b0, 32'h0000_0080);
    test_store_byte();
    test_align_fault();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid_access();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
